// File: rtl/rv32_regfile.sv
// Architectural register file (x0 hardwired zero) with a per-register pending-write scoreboard.
// Optional write-through forwarding is enabled by defining RV32_REGFILE_BYPASS_EN.
module rv32_regfile #(
  parameter int NUM_REGS = 32,
  parameter int PEND_W   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_data_i,
  input  logic [4:0]  wb_addr_i,
  input  logic        wb_en_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        issue_en_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        flush_i,
  output logic        rs1_busy_o,
  output logic        rs2_busy_o,
  output logic        issue_full_o,
  output logic        pend_err_o
);

  localparam logic [5:0]        NUM_REGS_W = 6'(NUM_REGS);
  localparam logic [PEND_W-1:0] CNT_MAX    = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] CNT_ONE    = PEND_W'(1);
  localparam logic [PEND_W-1:0] CNT_ZERO   = {PEND_W{1'b0}};

  logic [31:0]       regs_q [1:NUM_REGS-1];
  logic [PEND_W-1:0] cnt_q  [1:NUM_REGS-1];
  logic [PEND_W-1:0] cnt_d  [1:NUM_REGS-1];
  logic              err_q;
  logic              err_d;

  logic [31:0]       rs1_raw_s;
  logic [31:0]       rs2_raw_s;
  logic [PEND_W-1:0] rs1_cnt_s;
  logic [PEND_W-1:0] rs2_cnt_s;
  logic [PEND_W-1:0] ird_cnt_s;
  logic [PEND_W-1:0] wb_cnt_s;
  logic              inc_s;
  logic              dec_s;
  logic              rs1_fwd_s;
  logic              rs2_fwd_s;

  // True for a stored register (x0 and out-of-range addresses are not stored).
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && ({1'b0, a} < NUM_REGS_W);
  endfunction

  // Storage and counter lookups for each address consumer.
  always_comb begin
    rs1_raw_s = 32'd0;
    rs2_raw_s = 32'd0;
    rs1_cnt_s = CNT_ZERO;
    rs2_cnt_s = CNT_ZERO;
    ird_cnt_s = CNT_ZERO;
    wb_cnt_s  = CNT_ZERO;
    if (addr_ok(rs1_addr_i)) begin
      rs1_raw_s = regs_q[rs1_addr_i];
      rs1_cnt_s = cnt_q[rs1_addr_i];
    end else begin
      rs1_raw_s = 32'd0;
      rs1_cnt_s = CNT_ZERO;
    end
    if (addr_ok(rs2_addr_i)) begin
      rs2_raw_s = regs_q[rs2_addr_i];
      rs2_cnt_s = cnt_q[rs2_addr_i];
    end else begin
      rs2_raw_s = 32'd0;
      rs2_cnt_s = CNT_ZERO;
    end
    if (addr_ok(issue_rd_i)) begin
      ird_cnt_s = cnt_q[issue_rd_i];
    end else begin
      ird_cnt_s = CNT_ZERO;
    end
    if (addr_ok(wb_addr_i)) begin
      wb_cnt_s = cnt_q[wb_addr_i];
    end else begin
      wb_cnt_s = CNT_ZERO;
    end
  end

  assign issue_full_o = addr_ok(issue_rd_i) && (ird_cnt_s == CNT_MAX);
  assign inc_s        = issue_en_i && addr_ok(issue_rd_i) && !issue_full_o;
  assign dec_s        = wb_en_i && addr_ok(wb_addr_i);

`ifdef RV32_REGFILE_BYPASS_EN
  assign rs1_fwd_s = dec_s && (wb_addr_i == rs1_addr_i);
  assign rs2_fwd_s = dec_s && (wb_addr_i == rs2_addr_i);
`else
  assign rs1_fwd_s = 1'b0;
  assign rs2_fwd_s = 1'b0;
`endif

  assign rs1_data_o = rs1_fwd_s ? wb_data_i : rs1_raw_s;
  assign rs2_data_o = rs2_fwd_s ? wb_data_i : rs2_raw_s;
  // A landing write that retires the last outstanding count makes the operand ready now.
  assign rs1_busy_o = (rs1_cnt_s != CNT_ZERO) && !(rs1_fwd_s && (rs1_cnt_s == CNT_ONE));
  assign rs2_busy_o = (rs2_cnt_s != CNT_ZERO) && !(rs2_fwd_s && (rs2_cnt_s == CNT_ONE));
  assign pend_err_o = err_q;

  // Scoreboard next state: flush clears, coincident inc/dec cancel, dec at zero flags an error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (flush_i) begin
        cnt_d[i] = CNT_ZERO;
      end else begin
        case ({inc_s && (issue_rd_i == 5'(i)), dec_s && (wb_addr_i == 5'(i))})
          2'b10:   cnt_d[i] = cnt_q[i] + CNT_ONE;
          2'b01:   cnt_d[i] = (cnt_q[i] != CNT_ZERO) ? (cnt_q[i] - CNT_ONE) : CNT_ZERO;
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
    if (dec_s && (wb_cnt_s == CNT_ZERO)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Register file, counters and sticky error flag; reset has priority over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= 32'd0;
        cnt_q[i]  <= CNT_ZERO;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (dec_s && (wb_addr_i == 5'(i))) begin
          regs_q[i] <= wb_data_i;
        end
        cnt_q[i] <= cnt_d[i];
      end
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_rv32_regfile.sv
// Self-checking bench for rv32_regfile: directed scenarios followed by randomized traffic
// compared against an array-based reference model.
module tb_rv32_regfile;

  localparam int MAXC = 3;

`ifdef RV32_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_en;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        flush;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        issue_full;
  logic        pend_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg [32];
  int          m_cnt [32];
  bit          m_err;

  rv32_regfile dut (
    .clk_i(clk), .rst_i(rst),
    .wb_data_i(wb_data), .wb_addr_i(wb_addr), .wb_en_i(wb_en),
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
    .issue_en_i(issue_en), .issue_rd_i(issue_rd), .flush_i(flush),
    .rs1_busy_o(rs1_busy), .rs2_busy_o(rs2_busy),
    .issue_full_o(issue_full), .pend_err_o(pend_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the model, clock, update model.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input logic ie, input logic [4:0] ird,
                     input logic fl, input logic rs);
    bit f1, f2, full, inc, dec;
    logic [31:0] e1, e2;
    int c_wb;
    wb_en = we; wb_addr = wa; wb_data = wd;
    rs1_addr = a1; rs2_addr = a2;
    issue_en = ie; issue_rd = ird; flush = fl; rst = rs;
    #1;
    f1 = BYP && we && (wa == a1) && (a1 != 0);
    f2 = BYP && we && (wa == a2) && (a2 != 0);
    e1 = (a1 == 0) ? 32'd0 : (f1 ? wd : m_reg[a1]);
    e2 = (a2 == 0) ? 32'd0 : (f2 ? wd : m_reg[a2]);
    full = (ird != 0) && (m_cnt[ird] == MAXC);
    chk("rs1_data", rs1_data, e1);
    chk("rs2_data", rs2_data, e2);
    chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, (a1 != 0) && (m_cnt[a1] != 0) && !(f1 && m_cnt[a1] == 1)});
    chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, (a2 != 0) && (m_cnt[a2] != 0) && !(f2 && m_cnt[a2] == 1)});
    chk("issue_full", {31'd0, issue_full}, {31'd0, full});
    chk("pend_err", {31'd0, pend_err}, {31'd0, m_err});
    @(posedge clk);
    #1;
    if (rs) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i] = 32'd0;
        m_cnt[i] = 0;
      end
      m_err = 1'b0;
    end else begin
      inc  = ie && (ird != 0) && !full;
      dec  = we && (wa != 0);
      c_wb = m_cnt[wa];
      if (dec) m_reg[wa] = wd;
      if (dec && c_wb == 0) m_err = 1'b1;
      if (fl) begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      end else if (!(inc && dec && ird == wa)) begin
        if (inc) m_cnt[ird] = m_cnt[ird] + 1;
        if (dec && m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
      end
    end
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    cyc(1'b0, 5'd0, 32'd0, a1, a2, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 32'd0;
      m_cnt[i] = 0;
    end
    m_err = 1'b0;
    // Reset; model starts from the post-reset state so first checks are after reset.
    rst = 1'b1; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0; issue_en = 1'b0; issue_rd = 5'd0; flush = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    for (int i = 1; i < 32; i += 2) idle(5'(i), 5'(i + 1));
    chk("reset_full", {31'd0, issue_full}, 32'd0);

    // Write to x0 is ignored.
    cyc(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(5'd0, 5'd0);
    chk("x0_zero", rs1_data, 32'd0);

    // Write latency / forwarding on x5, with x5 pending once so the write-back is legal.
    cyc(1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    cyc(1'b1, 5'd5, 32'h12345678, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(5'd5, 5'd0);
    chk("x5_after", rs1_data, 32'h12345678);

    // Saturate x7: three issues, fourth refused, then three write-backs.
    for (int k = 0; k < 4; k++) cyc(1'b0, 5'd0, 32'd0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
    chk("x7_full", {31'd0, issue_full}, 32'd1);
    for (int k = 0; k < 3; k++) cyc(1'b1, 5'd7, 32'h70 + 32'(k), 5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0);
    idle(5'd7, 5'd7);
    chk("x7_idle", {31'd0, rs1_busy}, 32'd0);

    // Same-cycle issue and write-back on x9 with count 1.
    cyc(1'b0, 5'd0, 32'd0, 5'd0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
    cyc(1'b1, 5'd9, 32'h99, 5'd0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0);
    idle(5'd0, 5'd9);
    chk("x9_busy", {31'd0, rs2_busy}, 32'd1);
    cyc(1'b1, 5'd9, 32'h9A, 5'd0, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);

    // Write-back to x3 with nothing pending sets the sticky error.
    cyc(1'b1, 5'd3, 32'h33, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) idle(5'd3, 5'd0);
    chk("err_sticky", {31'd0, pend_err}, 32'd1);

    // Flush with x4 and x6 pending.
    cyc(1'b0, 5'd0, 32'd0, 5'd4, 5'd6, 1'b1, 5'd4, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 5'd4, 5'd6, 1'b1, 5'd6, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 32'd0, 5'd4, 5'd6, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(5'd4, 5'd6);
    chk("flush_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);

    // Reset during a write: register stays 0 and the error flag clears.
    cyc(1'b1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd3, 1'b1, 5'd12, 1'b0, 1'b1);
    idle(5'd12, 5'd3);
    chk("rst_wr", rs1_data, 32'd0);

    // Randomized traffic; write-backs only target registers with outstanding writes.
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] wa, ird, a1, a2;
      logic we, ie, fl, rs;
      wa  = 5'($urandom_range(0, 8));
      we  = ($urandom_range(0, 1) == 1) && ((wa == 0) || (m_cnt[wa] != 0));
      ird = 5'($urandom_range(0, 8));
      ie  = $urandom_range(0, 2) != 0;
      a1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 8));
      fl  = $urandom_range(0, 29) == 0;
      rs  = $urandom_range(0, 199) == 0;
      cyc(we, wa, $urandom, a1, a2, ie, ird, fl, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32_regfile.md
# rv32_regfile

Architectural register file and pending-write scoreboard for the rv32 pipeline. Sits on the receiving end of the write-back register-file write port (data, address, enable) and serves two combinational read ports to the decode stage. A per-register pending-write counter, incremented at issue and decremented at write-back, drives the decode stall logic.

## Interface
Parameters:
- `NUM_REGS`, 32, number of architectural registers (addresses 0..NUM_REGS-1; x0 hardwired zero)
- `PEND_W`, 2, width of each pending-write counter (max outstanding writes per register = 2^PEND_W-1)

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock, rising edge
- `rst_i` in 1: synchronous active-high reset
- `wb_data_i` in 32: write-back data
- `wb_addr_i` in 5: write-back destination register
- `wb_en_i` in 1: write-back enable (already qualified by valid upstream)
- `rs1_addr_i` in 5: read port 1 address
- `rs2_addr_i` in 5: read port 2 address
- `rs1_data_o` out 32: read port 1 data (combinational)
- `rs2_data_o` out 32: read port 2 data (combinational)
- `issue_en_i` in 1: instruction issuing this cycle that will write `issue_rd_i`
- `issue_rd_i` in 5: destination of issuing instruction
- `flush_i` in 1: clear all pending counters (pipeline flush)
- `rs1_busy_o` out 1: rs1 has an outstanding write not yet visible on read port
- `rs2_busy_o` out 1: rs2 same
- `issue_full_o` out 1: counter for `issue_rd_i` saturated; issue must stall
- `pend_err_o` out 1: sticky; write-back arrived for register with zero pending count

## Operation
- Storage: registers 1..31 of 32 bits; x0 not stored, always reads 0, writes to x0 ignored.
- Write: at rising edge, if `wb_en_i` and `wb_addr_i != 0`, reg[wb_addr_i] <= wb_data_i.
- Read: `rsN_data_o` = 0 if address 0, else reg[addr]; bypass per Configuration.
- Pending counters, one per register 1..31, updated at rising edge:
  - inc = `issue_en_i` && `issue_rd_i != 0` && !`issue_full_o`
  - dec = `wb_en_i` && `wb_addr_i != 0`
  - same register inc and dec: unchanged; inc only: +1; dec only: -1.
  - dec on counter 0: counter stays 0, `pend_err_o` <= 1 (sticky until reset).
  - `flush_i`: all counters <= 0 (overrides inc/dec); register writes still occur.
- `issue_full_o` = counter[issue_rd_i] == 2^PEND_W-1 && `issue_rd_i != 0` (combinational).
- `rsN_busy_o` = addr != 0 && counter[addr] != 0, with bypass exception below.

## Timing
- Reset (`rst_i` high at edge): all registers 0, all counters 0, `pend_err_o` 0. Reset wins over write, issue, flush the same edge. Consequently after reset `rsN_data_o`=0, `rsN_busy_o`=0, `issue_full_o`=0.
- Write latency: value written at edge N is readable from edge N (one cycle after presentation) without bypass; same cycle with bypass.
- Counter effect visible on busy outputs the cycle after the issuing edge.
- Reset mid-operation discards pending counts and error flag; no partial state.

## Configuration
- `RV32_REGFILE_BYPASS_EN` defined: write-through forwarding. When `wb_en_i` && `wb_addr_i == rsN_addr_i != 0`, `rsN_data_o` = `wb_data_i`, and `rsN_busy_o` is suppressed if counter[rsN] == 1 (last outstanding write is landing).
- Undefined: read returns stored value only; busy reflects counter only; decode stalls one extra cycle on RAW.

## Test plan
- Reset, read x1..x31 -> all 0; write x0=0xDEADBEEF -> x0 still reads 0.
- Write x5=0x12345678 at edge N, rs1_addr=5 in cycle N-1: with macro rs1_data=0x12345678 same cycle; without, old value 0 until after edge N.
- Issue rd=7 three times (PEND_W=2) -> counter 3, `issue_full_o`=1, fourth issue ignored; three write-backs to x7 -> `rs1_busy_o` drops after third.
- Same-cycle issue rd=9 and write-back x9 with count 1 -> count stays 1, `rs2_busy_o` stays 1.
- Write-back x3 with count 0 -> `pend_err_o`=1 and remains 1 until `rst_i`.
- Pending on x4,x6, assert `flush_i` -> next cycle both busy 0; reset asserted during simultaneous write -> register stays 0.
